// File: rtl/hif_i2c_slave.sv
// I2C slave engine: oversampled SCL/SDA, address match, register pointer/data strobes.
// Optional SCL-low timeout is enabled by defining HIF_I2C_TIMEOUT_EN.
module hif_i2c_slave #(
    parameter logic [6:0]  DEV_ADDR       = 7'h50,
    parameter int          SYNC_STAGES    = 2,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
    input  logic       xtal_clk,
    input  logic       por_rst_n,
    input  logic       hif_scl_del,
    input  logic       hif_sda_del,
    output logic       sda_oe,
    output logic       hif_idle,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata
);

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_ADDR       = 4'd1,
        ST_ADDR_ACK   = 4'd2,
        ST_WR_PTR     = 4'd3,
        ST_WR_DATA    = 4'd4,
        ST_WR_ACK     = 4'd5,
        ST_RD_LOAD    = 4'd6,
        ST_RD_DATA    = 4'd7,
        ST_RD_ACK_CHK = 4'd8,
        ST_IGNORE     = 4'd9
    } state_t;

    state_t               state_r, state_nxt;
    logic [SYNC_STAGES:0] scl_sync_r, sda_sync_r;
    logic [2:0]           bit_cnt_r, bit_cnt_nxt;
    logic [7:0]           shift_r, shift_nxt;
    logic [7:0]           reg_addr_r, addr_nxt;
    logic [7:0]           reg_wdata_r, wdata_nxt;
    logic                 sda_oe_r, sda_oe_nxt;
    logic                 idle_r, idle_nxt;
    logic                 reg_wr_r, wr_nxt;
    logic                 reg_rd_r, rd_nxt;
    logic                 rw_r, rw_nxt;
    logic                 mack_r, mack_nxt;
    logic                 ack_ph_r, ack_ph_nxt;
    logic                 scl_s, scl_prev_s, sda_s, sda_prev_s;
    logic                 scl_rise_s, scl_fall_s, start_s, stop_s, tmo_hit_s;
    logic [7:0]           byte_in_s;

    // Pad synchronizers; the top bit is the history sample used for edge detection
    always_ff @(posedge xtal_clk or negedge por_rst_n) begin
        if (!por_rst_n) begin
            scl_sync_r <= {(SYNC_STAGES+1){1'b1}};
            sda_sync_r <= {(SYNC_STAGES+1){1'b1}};
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-1:0], hif_scl_del};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-1:0], hif_sda_del};
        end
    end

    assign scl_s      = scl_sync_r[SYNC_STAGES-1];
    assign scl_prev_s = scl_sync_r[SYNC_STAGES];
    assign sda_s      = sda_sync_r[SYNC_STAGES-1];
    assign sda_prev_s = sda_sync_r[SYNC_STAGES];
    assign scl_rise_s = scl_s & ~scl_prev_s;
    assign scl_fall_s = ~scl_s & scl_prev_s;
    assign start_s    = scl_s & scl_prev_s & sda_prev_s & ~sda_s;
    assign stop_s     = scl_s & scl_prev_s & ~sda_prev_s & sda_s;
    assign byte_in_s  = {shift_r[6:0], sda_s};

`ifdef HIF_I2C_TIMEOUT_EN
    logic [15:0] tmo_cnt_r;

    // SCL-low watchdog, only armed while a transaction is open
    always_ff @(posedge xtal_clk or negedge por_rst_n) begin
        if (!por_rst_n) begin
            tmo_cnt_r <= 16'd0;
        end else if (scl_s || (state_r == ST_IDLE)) begin
            tmo_cnt_r <= 16'd0;
        end else if (tmo_cnt_r != TIMEOUT_CYCLES) begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    assign tmo_hit_s = ~scl_s && (state_r != ST_IDLE) && (tmo_cnt_r == TIMEOUT_CYCLES);
`else
    // No watchdog in this build; the parameter is referenced but never fires
    assign tmo_hit_s = (TIMEOUT_CYCLES == 16'd0) && 1'b0;
`endif

    // Next-state and next-output logic; START/STOP outrank timeout, which outranks bit events
    always_comb begin
        state_nxt   = state_r;
        bit_cnt_nxt = bit_cnt_r;
        shift_nxt   = shift_r;
        sda_oe_nxt  = sda_oe_r;
        idle_nxt    = idle_r;
        wdata_nxt   = reg_wdata_r;
        wr_nxt      = 1'b0;
        rd_nxt      = 1'b0;
        rw_nxt      = rw_r;
        mack_nxt    = mack_r;
        ack_ph_nxt  = ack_ph_r;
        if (reg_wr_r || reg_rd_r) begin
            addr_nxt = reg_addr_r + 8'd1;
        end else begin
            addr_nxt = reg_addr_r;
        end

        if (stop_s) begin
            state_nxt  = ST_IDLE;
            sda_oe_nxt = 1'b0;
            idle_nxt   = 1'b1;
            ack_ph_nxt = 1'b0;
        end else if (start_s) begin
            state_nxt   = ST_ADDR;
            bit_cnt_nxt = 3'd0;
            sda_oe_nxt  = 1'b0;
            idle_nxt    = 1'b0;
            ack_ph_nxt  = 1'b0;
        end else if (tmo_hit_s) begin
            state_nxt  = ST_IDLE;
            sda_oe_nxt = 1'b0;
            idle_nxt   = 1'b1;
            ack_ph_nxt = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt = ST_IDLE;
                end
                ST_ADDR, ST_WR_PTR, ST_WR_DATA: begin
                    if (scl_rise_s) begin
                        shift_nxt   = byte_in_s;
                        bit_cnt_nxt = bit_cnt_r + 3'd1;
                        if (bit_cnt_r != 3'd7) begin
                            state_nxt = state_r;
                        end else if (state_r == ST_ADDR) begin
                            rw_nxt    = byte_in_s[0];
                            state_nxt = (byte_in_s[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                        end else if (state_r == ST_WR_PTR) begin
                            addr_nxt  = byte_in_s;
                            state_nxt = ST_WR_ACK;
                        end else begin
                            wr_nxt    = 1'b1;
                            wdata_nxt = byte_in_s;
                            state_nxt = ST_WR_ACK;
                        end
                    end else begin
                        state_nxt = state_r;
                    end
                end
                // First fall after the byte drives ACK, the next fall ends the ACK bit
                ST_ADDR_ACK, ST_WR_ACK: begin
                    if (!scl_fall_s) begin
                        state_nxt = state_r;
                    end else if (!ack_ph_r) begin
                        sda_oe_nxt = 1'b1;
                        ack_ph_nxt = 1'b1;
                    end else begin
                        sda_oe_nxt  = 1'b0;
                        ack_ph_nxt  = 1'b0;
                        bit_cnt_nxt = 3'd0;
                        if (state_r == ST_WR_ACK) begin
                            state_nxt = ST_WR_DATA;
                        end else if (rw_r) begin
                            state_nxt = ST_RD_LOAD;
                            rd_nxt    = 1'b1;
                        end else begin
                            state_nxt = ST_WR_PTR;
                        end
                    end
                end
                ST_RD_LOAD: begin
                    shift_nxt   = reg_rdata;
                    sda_oe_nxt  = ~reg_rdata[7];
                    bit_cnt_nxt = 3'd0;
                    state_nxt   = ST_RD_DATA;
                end
                // bit_cnt counts rises; on a fall it names the next bit to drive (7 - cnt)
                ST_RD_DATA: begin
                    if (scl_rise_s) begin
                        bit_cnt_nxt = bit_cnt_r + 3'd1;
                    end else if (scl_fall_s && (bit_cnt_r == 3'd0)) begin
                        sda_oe_nxt = 1'b0;
                        state_nxt  = ST_RD_ACK_CHK;
                    end else if (scl_fall_s) begin
                        sda_oe_nxt = ~shift_r[~bit_cnt_r];
                    end else begin
                        state_nxt = ST_RD_DATA;
                    end
                end
                ST_RD_ACK_CHK: begin
                    if (scl_rise_s) begin
                        mack_nxt = sda_s;
                    end else if (scl_fall_s && !mack_r) begin
                        state_nxt = ST_RD_LOAD;
                        rd_nxt    = 1'b1;
                    end else if (scl_fall_s) begin
                        state_nxt = ST_IGNORE;
                    end else begin
                        state_nxt = ST_RD_ACK_CHK;
                    end
                end
                ST_IGNORE: begin
                    sda_oe_nxt = 1'b0;
                end
                default: begin
                    state_nxt  = ST_IDLE;
                    sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge xtal_clk or negedge por_rst_n) begin
        if (!por_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge xtal_clk or negedge por_rst_n) begin
        if (!por_rst_n) begin
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'd0;
            reg_addr_r  <= 8'd0;
            reg_wdata_r <= 8'd0;
            sda_oe_r    <= 1'b0;
            idle_r      <= 1'b1;
            reg_wr_r    <= 1'b0;
            reg_rd_r    <= 1'b0;
            rw_r        <= 1'b0;
            mack_r      <= 1'b1;
            ack_ph_r    <= 1'b0;
        end else begin
            bit_cnt_r   <= bit_cnt_nxt;
            shift_r     <= shift_nxt;
            reg_addr_r  <= addr_nxt;
            reg_wdata_r <= wdata_nxt;
            sda_oe_r    <= sda_oe_nxt;
            idle_r      <= idle_nxt;
            reg_wr_r    <= wr_nxt;
            reg_rd_r    <= rd_nxt;
            rw_r        <= rw_nxt;
            mack_r      <= mack_nxt;
            ack_ph_r    <= ack_ph_nxt;
        end
    end

    assign sda_oe    = sda_oe_r;
    assign hif_idle  = idle_r;
    assign reg_addr  = reg_addr_r;
    assign reg_wdata = reg_wdata_r;
    assign reg_wr    = reg_wr_r;
    assign reg_rd    = reg_rd_r;

endmodule

// File: tb/tb_hif_i2c_slave.sv
// Bench for hif_i2c_slave: bit-banged I2C master, strobe scoreboard and directed checks.
module tb_hif_i2c_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe, hif_idle, reg_wr, reg_rd;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;

    typedef struct {
        logic       is_wr;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_e;
    int         total = 0;
    int         bad = 0;
    int         oe_cnt = 0;
    int         oe_snap;
    logic       ack;
    logic [7:0] rb;

    always #5 clk = ~clk;

    assign sda_line  = sda_m & ~sda_oe;
    assign reg_rdata = reg_addr ^ 8'hFF;

    hif_i2c_slave #(
        .DEV_ADDR(7'h50),
        .SYNC_STAGES(2),
        .TIMEOUT_CYCLES(16'd100)
    ) dut (
        .xtal_clk(clk),
        .por_rst_n(rst_n),
        .hif_scl_del(scl_m),
        .hif_sda_del(sda_line),
        .sda_oe(sda_oe),
        .hif_idle(hif_idle),
        .reg_addr(reg_addr),
        .reg_wdata(reg_wdata),
        .reg_wr(reg_wr),
        .reg_rd(reg_rd),
        .reg_rdata(reg_rdata)
    );

    always @(posedge clk) begin
        if (sda_oe) oe_cnt <= oe_cnt + 1;
    end

    // Scoreboard monitor: every strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n && (reg_wr || reg_rd)) begin
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL strobe_unexpected: wr=%0b rd=%0b addr=%h data=%h, none expected",
                         reg_wr, reg_rd, reg_addr, reg_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ((reg_wr !== mon_e.is_wr) || (reg_rd !== !mon_e.is_wr) ||
                    (reg_addr !== mon_e.addr) || (mon_e.is_wr && (reg_wdata !== mon_e.data))) begin
                    bad = bad + 1;
                    $display("FAIL strobe: got wr=%0b rd=%0b addr=%h data=%h, want wr=%0b addr=%h data=%h",
                             reg_wr, reg_rd, reg_addr, reg_wdata, mon_e.is_wr, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0b want %0b", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back('{1'b1, a, d});
    endtask

    task automatic push_rd(input logic [7:0] a);
        exp_q.push_back('{1'b0, a, 8'h00});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; cyc(6);
        scl_m = 1'b1; cyc(12);
        sda_m = 1'b0; cyc(12);
        scl_m = 1'b0; cyc(6);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; cyc(6);
        scl_m = 1'b1; cyc(12);
        sda_m = 1'b1; cyc(12);
    endtask

    task automatic bit_out(input logic b);
        sda_m = b; cyc(6);
        scl_m = 1'b1; cyc(12);
        scl_m = 1'b0; cyc(6);
    endtask

    task automatic byte_out(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        sda_m = 1'b1; cyc(6);
        scl_m = 1'b1; cyc(6);
        a = sda_line; cyc(6);
        scl_m = 1'b0; cyc(6);
    endtask

    task automatic byte_in(output logic [7:0] b, input logic mack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; cyc(6);
            scl_m = 1'b1; cyc(6);
            b[i] = sda_line; cyc(6);
            scl_m = 1'b0; cyc(6);
        end
        bit_out(mack);
    endtask

    initial begin
        cyc(5);
        check1("rst_sda_oe", sda_oe, 1'b0);
        check1("rst_idle", hif_idle, 1'b1);
        check8("rst_addr", reg_addr, 8'h00);
        check8("rst_wdata", reg_wdata, 8'h00);
        check1("rst_wr", reg_wr, 1'b0);
        check1("rst_rd", reg_rd, 1'b0);
        rst_n = 1'b1;
        cyc(5);

        // Write two bytes starting at 0x10
        push_wr(8'h10, 8'h5A);
        push_wr(8'h11, 8'hC3);
        i2c_start();
        byte_out(8'hA0, ack); check1("wr_ack_addr", ack, 1'b0);
        check1("wr_busy", hif_idle, 1'b0);
        byte_out(8'h10, ack); check1("wr_ack_ptr", ack, 1'b0);
        byte_out(8'h5A, ack); check1("wr_ack_d0", ack, 1'b0);
        byte_out(8'hC3, ack); check1("wr_ack_d1", ack, 1'b0);
        i2c_stop(); cyc(4);
        check8("wr_final_addr", reg_addr, 8'h12);
        check1("wr_idle", hif_idle, 1'b1);

        // Read with repeated start, rdata = addr ^ 0xFF
        push_rd(8'h20);
        push_rd(8'h21);
        i2c_start();
        byte_out(8'hA0, ack); check1("rd_ack_waddr", ack, 1'b0);
        byte_out(8'h20, ack); check1("rd_ack_ptr", ack, 1'b0);
        i2c_start();
        byte_out(8'hA1, ack); check1("rd_ack_raddr", ack, 1'b0);
        byte_in(rb, 1'b0); check8("rd_byte0", rb, 8'hDF);
        byte_in(rb, 1'b1); check8("rd_byte1", rb, 8'hDE);
        i2c_stop(); cyc(4);
        check8("rd_final_addr", reg_addr, 8'h22);

        // Address mismatch: no ACK, no strobes, pointer untouched
        oe_snap = oe_cnt;
        i2c_start();
        byte_out(8'hA2, ack); check1("mm_nack_addr", ack, 1'b1);
        byte_out(8'h00, ack); check1("mm_nack_data", ack, 1'b1);
        i2c_stop(); cyc(4);
        check8("mm_oe_cycles", 8'(oe_cnt - oe_snap), 8'h00);
        check8("mm_addr", reg_addr, 8'h22);

        // Pointer wrap 0xFF -> 0x00
        push_wr(8'hFF, 8'h01);
        push_wr(8'h00, 8'h02);
        i2c_start();
        byte_out(8'hA0, ack); check1("wrap_ack_addr", ack, 1'b0);
        byte_out(8'hFF, ack); check1("wrap_ack_ptr", ack, 1'b0);
        byte_out(8'h01, ack); check1("wrap_ack_d0", ack, 1'b0);
        byte_out(8'h02, ack); check1("wrap_ack_d1", ack, 1'b0);
        i2c_stop(); cyc(4);
        check8("wrap_addr", reg_addr, 8'h01);

        // STOP after 4 data bits: partial byte dropped
        i2c_start();
        byte_out(8'hA0, ack); check1("abort_ack_addr", ack, 1'b0);
        byte_out(8'h40, ack); check1("abort_ack_ptr", ack, 1'b0);
        bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
        i2c_stop(); cyc(4);
        check1("abort_idle", hif_idle, 1'b1);
        check8("abort_addr", reg_addr, 8'h40);

        // Reset during read address ACK releases SDA without a clock edge
        i2c_start();
        for (int i = 7; i >= 0; i--) bit_out(1'(8'hA1 >> i));
        sda_m = 1'b1; cyc(6);
        scl_m = 1'b1; cyc(3);
        check1("rst_pre_ack_drv", sda_oe, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check1("rst_async_release", sda_oe, 1'b0);
        sda_m = 1'b1;
        cyc(5);
        rst_n = 1'b1;
        cyc(5);
        check8("rst_mid_addr", reg_addr, 8'h00);
        check1("rst_mid_idle", hif_idle, 1'b1);

        // SCL held low after the address ACK
        i2c_start();
        byte_out(8'hA0, ack); check1("tmo_ack_addr", ack, 1'b0);
        check1("tmo_busy", hif_idle, 1'b0);
        cyc(150);
`ifdef HIF_I2C_TIMEOUT_EN
        check1("tmo_idle", hif_idle, 1'b1);
`else
        check1("tmo_stuck", hif_idle, 1'b0);
`endif
        check1("tmo_sda_oe", sda_oe, 1'b0);
        i2c_stop(); cyc(4);
        check1("tmo_end_idle", hif_idle, 1'b1);

        cyc(10);
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL strobe_missing: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hif_i2c_slave.md
# hif_i2c_slave

I2C slave protocol engine for the host interface of the OTP controller digital top. It oversamples the pad-delayed SCL/SDA lines with `xtal_clk`, decodes START/STOP, address and data bytes, and drives the open-drain SDA pull-down. It presents a simple one-cycle register read/write strobe interface to the register/OTP block downstream, and reports bus idleness on `hif_idle`.

## Interface
- `DEV_ADDR`, 7'h50: 7-bit slave address matched after START.
- `SYNC_STAGES`, 2: synchronizer depth on SCL and SDA (min 2).
- `TIMEOUT_CYCLES`, 65535: SCL-low timeout in `xtal_clk` cycles. Used only with `HIF_I2C_TIMEOUT_EN`. Width 16.
- `xtal_clk`  in  1  sole clock, rising edge.
- `por_rst_n`  in  1  asynchronous active-low reset.
- `hif_scl_del`  in  1  delayed SCL from pad.
- `hif_sda_del`  in  1  delayed SDA from pad.
- `sda_oe`  out  1  1 = pull SDA low; 0 = release.
- `hif_idle`  out  1  1 when no transaction is in progress between START and STOP.
- `reg_addr`  out  8  register pointer.
- `reg_wdata`  out  8  write data, valid with `reg_wr`.
- `reg_wr`  out  1  one-cycle write strobe.
- `reg_rd`  out  1  one-cycle read strobe.
- `reg_rdata`  in  8  read data. Combinational from `reg_addr` and sampled on the clock edge that ends the `reg_rd` cycle.

## Operation
- SCL and SDA each pass through a `SYNC_STAGES` flop chain plus one history flop. Edges are derived from the last two samples.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are valid in any state, and START acts as a repeated start.
- Bits are sampled on SCL rising edges, MSB first. `sda_oe` changes only on SCL falling edges, except that START and STOP release it immediately.
- States:
  - IDLE: wait for START, then go to ADDR.
  - ADDR: shift 8 bits (7-bit address plus R/W). On address match go to ADDR_ACK. On mismatch go to IGNORE.
  - ADDR_ACK: drive ACK for one SCL period. W goes to WR_PTR. R goes to RD_LOAD.
  - WR_PTR: shift 8 bits into `reg_addr`, then go to WR_ACK.
  - WR_DATA: shift 8 bits. At the 8th rising edge, pulse `reg_wr` with `reg_wdata` = byte, then go to WR_ACK.
  - WR_ACK: drive ACK for one SCL period, then go to WR_DATA.
  - RD_LOAD: pulse `reg_rd` and capture `reg_rdata` into the shift register, then go to RD_DATA.
  - RD_DATA: drive bits (`sda_oe` = ~bit), then go to RD_ACK_CHK.
  - RD_ACK_CHK: sample the master ACK. ACK (0) goes to RD_LOAD. NACK (1) goes to IGNORE.
  - IGNORE: `sda_oe` = 0 and wait for START or STOP.
- STOP from any state goes to IDLE. START from any state goes to ADDR.
- `reg_addr` increments by 1 after every `reg_wr` and after every `reg_rd`. It wraps 8'hFF to 8'h00. The pointer is retained across transactions.
- A STOP or START in the middle of a byte discards the partial byte and produces no strobe.
- `hif_idle` = 0 from the cycle START is detected until the cycle STOP is detected or a timeout fires. Otherwise it is 1.
- Reset values:
  - state IDLE
  - `sda_oe` = 0, `hif_idle` = 1
  - `reg_addr` = 0, `reg_wdata` = 0
  - `reg_wr` = 0, `reg_rd` = 0
  - synchronizers = 1
- Reset asserted mid-transfer releases SDA asynchronously.

## Timing
- Pad-to-detect latency is `SYNC_STAGES` + 1 `xtal_clk` cycles.
- SCL high and SCL low must each last at least `SYNC_STAGES` + 3 cycles. Required: `xtal_clk` ≥ 10× SCL rate, i.e. 100 MHz supports 400 kHz with margin.
- `reg_wr` asserts 1 cycle after the detected 8th data rising edge. It is exactly 1 cycle wide.
- `reg_rd` asserts 1 cycle after:
  - the detected SCL fall ending the address ACK, or
  - the detected SCL fall following an ACK in RD_ACK_CHK.
- The first read bit is driven no later than 2 cycles after that fall.
- `sda_oe` updates 1 cycle after the detected SCL fall.
- Simultaneous START/STOP detection with a bit edge cannot occur, because the SDA and SCL edges are separated. When START/STOP and a timeout occur in the same cycle, START/STOP wins.

## Configuration
- `HIF_I2C_TIMEOUT_EN` defined:
  - a 16-bit counter counts cycles while synchronized SCL = 0 and the state is not IDLE;
  - it clears on SCL high;
  - when it reaches `TIMEOUT_CYCLES`, the FSM goes to IDLE, `sda_oe` = 0 and `hif_idle` = 1, with no strobes.
- `HIF_I2C_TIMEOUT_EN` undefined: no counter exists, `TIMEOUT_CYCLES` is ignored, and a stuck-low SCL holds the FSM indefinitely.

## Test plan
- Write: START, 0xA0, 0x10, 0x5A, 0xC3, STOP. Required: ACK on all four bytes; `reg_wr` pulses with (0x10, 0x5A) then (0x11, 0xC3); final `reg_addr` = 0x12; `hif_idle` returns to 1.
- Read with repeated start: START, 0xA0, 0x20, Sr, 0xA1, master ACK, NACK, STOP. With `reg_rdata` = addr^0xFF, required: bytes 0xDF then 0xDE on SDA; two `reg_rd` pulses; `reg_addr` = 0x22.
- Address mismatch: START, 0xA2, 0x00, STOP. Required: no ACK (`sda_oe` stays 0), no strobes, `reg_addr` unchanged.
- Wrap: write pointer 0xFF, then data 0x01 and 0x02. Required: writes land at 0xFF then 0x00; `reg_addr` = 0x01.
- Abort: STOP after 4 bits of a data byte. Required: no `reg_wr`, state IDLE, `hif_idle` = 1. Reset asserted during a read ACK releases `sda_oe` immediately.
- Timeout (macro defined, `TIMEOUT_CYCLES` = 100): hold SCL low after the address ACK. Required: at 100 cycles `hif_idle` = 1 and `sda_oe` = 0. Without the macro: `hif_idle` stays 0.
